// File: rtl/ram_bist_pkg.sv
// ---------------------------------------------------------------------------
// ram_bist_pkg
// Shared definitions for the RAM march-test BIST controller:
//   - default geometry / read-latency constants
//   - controller FSM state encoding
// ---------------------------------------------------------------------------
package ram_bist_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 4;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR0   = 3'd1,
    ST_RD0   = 3'd2,
    ST_WR1   = 3'd3,
    ST_RD1   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } bist_state_e;

endpackage

// File: rtl/ram_bist_cmp.sv
// ---------------------------------------------------------------------------
// ram_bist_cmp
// Carries the expected read data and its address alongside the RAM read
// latency, then compares against the returned RAM data. The compare result
// is registered, so a mismatch pulse appears one edge after the data it
// judged.
//
// Ports:
//   clk, rst_n      clock / async active-low reset (valids and result flag)
//   i_flush         drop everything in flight (new test or abort)
//   i_vld           a read address is being issued this cycle
//   i_addr, i_exp   address and expected data of that read
//   i_rdata         RAM read data (valid RD_LAT cycles after the address)
//   o_mis           registered mismatch pulse
//   o_mis_addr      address of the mismatching read
//   o_mis_data      data actually returned by the RAM
// ---------------------------------------------------------------------------
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_mis,
  output logic [ADDR_W-1:0] o_mis_addr,
  output logic [DATA_W-1:0] o_mis_data
);

  logic [RD_LAT-1:0] r_vld_p;
  logic [DATA_W-1:0] r_exp_p  [RD_LAT];
  logic [ADDR_W-1:0] r_addr_p [RD_LAT];
  logic              r_mis;
  logic [ADDR_W-1:0] r_mis_addr;
  logic [DATA_W-1:0] r_mis_data;
  logic              w_neq;

  assign w_neq = r_vld_p[RD_LAT-1] && (i_rdata != r_exp_p[RD_LAT-1]);

  // Delay line control: valids and the registered mismatch flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
      r_mis   <= 1'b0;
    end else if (i_flush) begin
      r_vld_p <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
      r_mis <= w_neq;
    end
  end

  // Delay line data: qualified by the valids, so no reset needed
  always_ff @(posedge clk) begin
    r_exp_p[0]  <= i_exp;
    r_addr_p[0] <= i_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      r_exp_p[i]  <= r_exp_p[i-1];
      r_addr_p[i] <= r_addr_p[i-1];
    end
    r_mis_addr <= r_addr_p[RD_LAT-1];
    r_mis_data <= i_rdata;
  end

  assign o_mis      = r_mis;
  assign o_mis_addr = r_mis_addr;
  assign o_mis_data = r_mis_data;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
// Four-phase march BIST for a synchronous RAM: write P0 = addr, read/check
// P0, write P1 = ~addr, read/check P1, drain the read pipeline, report.
//
// Ports:
//   clk, rst_n      clock / async active-low reset
//   start           launch a test (accepted only in IDLE or DONE)
//   ram_data_in     write data to RAM
//   ram_rw          1 = write, 0 = read
//   ram_address     RAM address
//   ram_data_out    RAM read data, RD_LAT cycles after the address
//   busy            test running
//   done            test finished, held until the next start
//   pass            result, valid while done = 1
//   fail_addr       address of the first mismatch
//   fail_data       data read at the first mismatch
//   err_cnt         (BIST_ERR_COUNT_EN only) saturating mismatch count
//
// Build option BIST_ERR_COUNT_EN:
//   undefined - the test aborts to DONE on the first mismatch
//   defined   - the test always runs to completion and counts mismatches
// ---------------------------------------------------------------------------
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`ifdef BIST_ERR_COUNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int CNT_W = $clog2(RD_LAT + 1) + 1;

  bist_state_e       r_state;
  bist_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_drain_cnt;
  logic              r_pass;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic              w_start;
  logic              w_last;
  logic              w_sweep;
  logic              w_active;
  logic              w_take;
  logic              w_abort;
  logic              w_flush;
  logic              w_rd_vld;
  logic [DATA_W-1:0] w_rd_exp;
  logic              w_mis;
  logic [ADDR_W-1:0] w_mis_addr;
  logic [DATA_W-1:0] w_mis_data;

  assign w_start  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = &r_addr;
  assign w_sweep  = r_state inside {ST_WR0, ST_RD0, ST_WR1, ST_RD1};
  assign w_active = w_sweep || (r_state == ST_DRAIN);
  assign w_take   = w_mis && w_active;

`ifdef BIST_ERR_COUNT_EN
  logic [15:0] r_err_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign w_abort = 1'b0;
  assign err_cnt = r_err_cnt;
`else
  assign w_abort = w_take;
`endif

  // A fresh test and an abort both discard compares still in flight
  assign w_flush  = w_start || w_abort;
  assign w_rd_vld = (r_state == ST_RD0 || r_state == ST_RD1) && !w_abort;
  assign w_rd_exp = (r_state == ST_RD0) ? r_addr[DATA_W-1:0] : ~r_addr[DATA_W-1:0];

  ram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (w_flush),
    .i_vld      (w_rd_vld),
    .i_addr     (r_addr),
    .i_exp      (w_rd_exp),
    .i_rdata    (ram_data_out),
    .o_mis      (w_mis),
    .o_mis_addr (w_mis_addr),
    .o_mis_data (w_mis_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start) w_state_nxt = ST_WR0;
      ST_WR0:           if (w_last)  w_state_nxt = ST_RD0;
      ST_RD0:           if (w_last)  w_state_nxt = ST_WR1;
      ST_WR1:           if (w_last)  w_state_nxt = ST_RD1;
      ST_RD1:           if (w_last)  w_state_nxt = ST_DRAIN;
      // Wait out the read latency plus the registered compare so the
      // final result is already in pass/fail when done rises.
      ST_DRAIN:         if (r_drain_cnt == CNT_W'(RD_LAT)) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_DONE;
  end

  // FSM outputs
  always_comb begin
    ram_rw      = 1'b0;
    ram_data_in = '0;
    ram_address = r_addr;
    busy        = w_active;
    done        = (r_state == ST_DONE);
    case (r_state)
      ST_WR0: begin
        ram_rw      = !w_abort;
        ram_data_in = r_addr[DATA_W-1:0];
      end
      ST_WR1: begin
        ram_rw      = !w_abort;
        ram_data_in = ~r_addr[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  // Address sweep and drain counters; the address wraps into the next phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_flush || !w_sweep) r_addr <= '0;
      else                     r_addr <= r_addr + 1'b1;
      if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                     r_drain_cnt <= '0;
    end
  end

  // Result registers: only the first mismatch of a run is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
`ifdef BIST_ERR_COUNT_EN
      r_err_cnt   <= '0;
`endif
    end else if (w_start) begin
      r_pass      <= 1'b1;
      r_fail_addr <= '0;
      r_fail_data <= '0;
`ifdef BIST_ERR_COUNT_EN
      r_err_cnt   <= '0;
`endif
    end else if (w_take) begin
      if (r_pass) begin
        r_pass      <= 1'b0;
        r_fail_addr <= w_mis_addr;
        r_fail_data <= w_mis_data;
      end
`ifdef BIST_ERR_COUNT_EN
      r_err_cnt <= sat_inc16(r_err_cnt);
`endif
    end
  end

  assign pass      = r_pass;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_ctrl
// Directed bench for ram_bist_ctrl (ADDR_W=4, DATA_W=4, RD_LAT=1) with a
// behavioural 1-cycle-latency RAM that can hold bit0 stuck-at-0 per address.
// Expected RAM writes are queued when a test is launched and popped by a
// write monitor as the controller issues them.
// ---------------------------------------------------------------------------
module tb_ram_bist_ctrl;

  localparam int AW = 4;
  localparam int DW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] ram_data_in;
  logic          ram_rw;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
`ifdef BIST_ERR_COUNT_EN
  logic [15:0]   err_cnt;
`endif

  logic [DW-1:0] mem [16];
  logic [15:0]   stuck0;
  wr_t           exp_wr_q[$];
  int            n_chk;
  int            n_fail;
  int            edge_cnt;
  int            s_edge;
  int            dt;

  ram_bist_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ram_data_in  (ram_data_in),
    .ram_rw       (ram_rw),
    .ram_address  (ram_address),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data)
`ifdef BIST_ERR_COUNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Behavioural RAM: synchronous write, registered read (latency 1)
  always @(posedge clk) begin
    if (ram_rw) mem[ram_address] <= ram_data_in;
    ram_data_out <= stuck0[ram_address] ? (mem[ram_address] & 4'b1110) : mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every RAM write must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && ram_rw) begin
      chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        wr_t e;
        e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e.a));
        chk("wr_data", 32'(ram_data_in), 32'(e.d));
      end
    end
  end

  task automatic push_writes(input int phases);
    for (int p = 0; p < phases; p++) begin
      for (int a = 0; a < 16; a++) begin
        wr_t e;
        e.a = 4'(a);
        e.d = (p == 0) ? 4'(a) : ~4'(a);
        exp_wr_q.push_back(e);
      end
    end
  endtask

  task automatic start_test();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    s_edge = edge_cnt;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        d = edge_cnt - s_edge;
        break;
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    edge_cnt = 0;
    stuck0   = '0;
    start    = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random start activity: everything held at zero
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) start = 1'($urandom_range(0, 1));
      #1;
      chk("rst_rw",    32'(ram_rw), 32'd0);
      chk("rst_addr",  32'(ram_address), 32'd0);
      chk("rst_wdata", 32'(ram_data_in), 32'd0);
      chk("rst_flags", 32'({busy, done, pass}), 32'd0);
      chk("rst_fail",  32'({fail_addr, fail_data}), 32'd0);
`ifdef BIST_ERR_COUNT_EN
      chk("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
    end
    @(negedge clk) start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fault-free run
    push_writes(2);
    start_test();
    chk("busy_after_start", 32'({busy, done, pass}), 32'b101);
    wait_done(dt);
    chk("ff_done_edge", 32'(dt), 32'd66);
    chk("ff_pass", 32'(pass), 32'd1);
    chk("ff_busy", 32'(busy), 32'd0);
    chk("ff_mem5", 32'(mem[5]), 32'hA);
    chk("ff_wr_left", 32'(exp_wr_q.size()), 32'd0);
`ifdef BIST_ERR_COUNT_EN
    chk("ff_errcnt", 32'(err_cnt), 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);

    // Restart from DONE with a spurious start while busy
    push_writes(2);
    start_test();
    chk("restart_done_clr", 32'({busy, done}), 32'b10);
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(dt);
    chk("busy_start_done_edge", 32'(dt), 32'd66);
    chk("busy_start_pass", 32'(pass), 32'd1);
    chk("busy_start_wr_left", 32'(exp_wr_q.size()), 32'd0);

    // Reset in the middle of RD0, then a complete new run
    push_writes(2);
    start_test();
    repeat (19) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rw", 32'(ram_rw), 32'd0);
    chk("mid_rst_flags", 32'({busy, done, pass}), 32'd0);
    exp_wr_q.delete();
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_rw", 32'(ram_rw), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'({busy, done, ram_rw}), 32'd0);
    push_writes(2);
    start_test();
    wait_done(dt);
    chk("rerun_done_edge", 32'(dt), 32'd66);
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_wr_left", 32'(exp_wr_q.size()), 32'd0);

`ifdef BIST_ERR_COUNT_EN
    // Bit0 stuck-at-0 at 3 (caught in RD0) and 6 (caught in RD1)
    stuck0[3] = 1'b1;
    stuck0[6] = 1'b1;
    push_writes(2);
    start_test();
    wait_done(dt);
    chk("cnt_done_edge", 32'(dt), 32'd66);
    chk("cnt_errcnt", 32'(err_cnt), 32'd2);
    chk("cnt_pass", 32'(pass), 32'd0);
    chk("cnt_fail_addr", 32'(fail_addr), 32'd3);
    chk("cnt_fail_data", 32'(fail_data), 32'h2);
    chk("cnt_wr_left", 32'(exp_wr_q.size()), 32'd0);
`else
    // Bit0 stuck-at-0 at 3: abort after the RD0 compare, WR1 never starts
    stuck0[3] = 1'b1;
    push_writes(1);
    start_test();
    wait_done(dt);
    chk("abort_done_edge", 32'(dt), 32'd22);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_fail_addr", 32'(fail_addr), 32'd3);
    chk("abort_fail_data", 32'(fail_data), 32'h2);
    chk("abort_rw", 32'(ram_rw), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_done_held", 32'({busy, done}), 32'b01);
    chk("abort_wr_left", 32'(exp_wr_q.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
